// File: rtl/cic_decim_ctrl_if.sv
// Ratio-request handshake between a configuration master and the CIC decimator controller.
interface cic_decim_ctrl_if;
  logic        cfg_valid;
  logic [15:0] cfg_ratio;
  logic        cfg_ready;
  logic        cfg_err;

  modport master (output cfg_valid, output cfg_ratio, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_ratio, output cfg_ready, output cfg_err);
endinterface

// File: rtl/cic_decim_ctrl.sv
// Reconfiguration sequencer for a CIC decimator: range-check, shift calc, flush, settle.
// Optional settle watchdog enabled by defining CIC_DECIM_CTRL_TIMEOUT_EN.
module cic_decim_ctrl #(
  parameter int unsigned STAGES         = 5,
  parameter int unsigned MIN_RATIO      = 2,
  parameter int unsigned MAX_RATIO      = 4096,
  parameter int unsigned DEFAULT_RATIO  = 64,
  parameter int unsigned FLUSH_CYCLES   = 8,
  parameter int unsigned SETTLE_SAMPLES = 5,
  parameter int unsigned SHIFT_MAX      = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  cic_decim_ctrl_if.slave        cfg,
  input  logic                   cic_dclk,
  output logic                   cic_rst,
  output logic [15:0]            cic_ratio,
  output logic [5:0]             cic_shift,
  output logic                   out_en,
  output logic                   busy,
  output logic                   fault
);

  typedef enum logic [1:0] {StRun, StCalc, StFlush, StSettle} state_e;

  state_e      state_q, state_d;
  logic [15:0] pend_ratio_q, pend_ratio_d;
  logic [15:0] cic_ratio_q;
  logic [5:0]  cic_shift_q, shift_next_q, shift_calc;
  logic [4:0]  k_q;
  logic [15:0] cnt_q;
  logic        dclk_q, dclk_rise;
  logic        cfg_err_q;
  logic        out_en_q, out_en_d, cic_rst_q, cic_rst_d;
  logic        req_fire, req_bad, req_same;
  logic        calc_done, flush_done, settle_done, timeout;
  logic [31:0] shift_full;

  assign dclk_rise   = cic_dclk & ~dclk_q;
  assign req_fire    = (state_q == StRun) & cfg.cfg_valid;
  assign req_bad     = (32'(cfg.cfg_ratio) < MIN_RATIO) || (32'(cfg.cfg_ratio) > MAX_RATIO);
  assign req_same    = (cfg.cfg_ratio == cic_ratio_q);
  assign calc_done   = ((32'd1 << k_q) >= 32'(pend_ratio_q));
  assign flush_done  = (cnt_q == 16'(FLUSH_CYCLES - 1));
  assign settle_done = dclk_rise && (cnt_q == 16'(SETTLE_SAMPLES - 1));
  assign shift_full  = STAGES * 32'(k_q);
  assign shift_calc  = (shift_full > SHIFT_MAX) ? 6'(SHIFT_MAX) : shift_full[5:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCalc;
      pend_ratio_q <= 16'(DEFAULT_RATIO);
    end else begin
      state_q      <= state_d;
      pend_ratio_q <= pend_ratio_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d      = state_q;
    pend_ratio_d = pend_ratio_q;
    unique case (state_q)
      StRun: begin
        if (req_fire && !req_bad && !req_same) begin
          pend_ratio_d = cfg.cfg_ratio;
          state_d      = StCalc;
        end
      end
      StCalc:   if (calc_done) state_d = StFlush;
      StFlush:  if (flush_done) state_d = StSettle;
      StSettle: begin
        if (settle_done)  state_d = StRun;
        else if (timeout) state_d = StFlush;
      end
      default:  state_d = StCalc;
    endcase
  end

  // FSM outputs: CALC holds whatever enable/reset levels it was entered with
  always_comb begin
    out_en_d  = out_en_q;
    cic_rst_d = cic_rst_q;
    unique case (state_d)
      StRun:    begin out_en_d = 1'b1; cic_rst_d = 1'b0; end
      StFlush:  begin out_en_d = 1'b0; cic_rst_d = 1'b1; end
      StSettle: begin out_en_d = 1'b0; cic_rst_d = 1'b0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q          <= '0;
      shift_next_q <= '0;
      cnt_q        <= '0;
      dclk_q       <= 1'b1;
      cfg_err_q    <= 1'b0;
      out_en_q     <= 1'b0;
      cic_rst_q    <= 1'b1;
      cic_ratio_q  <= 16'(DEFAULT_RATIO);
      cic_shift_q  <= '0;
    end else begin
      dclk_q    <= cic_dclk;
      cfg_err_q <= req_fire & req_bad;
      out_en_q  <= out_en_d;
      cic_rst_q <= cic_rst_d;
      k_q       <= (state_q == StCalc && !calc_done) ? k_q + 5'd1 : '0;
      if (state_q == StCalc && calc_done) shift_next_q <= shift_calc;
      // One counter serves both flush cycles and settle edges; any state change clears it
      if (state_d != state_q)                       cnt_q <= '0;
      else if (state_q == StFlush)                  cnt_q <= cnt_q + 16'd1;
      else if (state_q == StSettle && dclk_rise)    cnt_q <= cnt_q + 16'd1;
      if (state_q == StFlush && cnt_q == '0) begin
        cic_ratio_q <= pend_ratio_q;
        cic_shift_q <= shift_next_q;
      end
    end
  end

`ifdef CIC_DECIM_CTRL_TIMEOUT_EN
  localparam int unsigned WdLimit = 2 * MAX_RATIO + 16;
  localparam int unsigned WdW     = $clog2(WdLimit + 1);

  logic [WdW-1:0] wd_q;
  logic           fault_q;

  assign timeout = (state_q == StSettle) && !dclk_rise && (wd_q == WdW'(WdLimit - 1));
  assign fault   = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q != StSettle || dclk_rise || timeout) wd_q <= '0;
      else                                             wd_q <= wd_q + 1'b1;
      if (timeout) fault_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  assign cfg.cfg_ready = (state_q == StRun);
  assign cfg.cfg_err   = cfg_err_q;
  assign busy          = (state_q != StRun);
  assign out_en        = out_en_q;
  assign cic_rst       = cic_rst_q;
  assign cic_ratio     = cic_ratio_q;
  assign cic_shift     = cic_shift_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; define CIC_DECIM_CTRL_TIMEOUT_EN for the watchdog variant.
module tb_cic_decim_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cic_dclk = 1'b0;
  logic        cic_rst, out_en, busy, fault;
  logic [15:0] cic_ratio;
  logic [5:0]  cic_shift;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic        dclk_en = 1'b1;
  int unsigned phase = 0;
  logic        dclk_last = 1'b1;
  logic        dclk_rise_seen = 1'b0;

  cic_decim_ctrl_if cfg_bus ();

  cic_decim_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_bus),
    .cic_dclk  (cic_dclk),
    .cic_rst   (cic_rst),
    .cic_ratio (cic_ratio),
    .cic_shift (cic_shift),
    .out_en    (out_en),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Sample clock with period 64 clk cycles, changed just after the active edge
  initial forever begin
    @(posedge clk);
    #1;
    if (dclk_en) begin
      phase++;
      cic_dclk = phase[5];
    end else begin
      cic_dclk = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    dclk_rise_seen = cic_dclk & ~dclk_last;
    dclk_last      = cic_dclk;
  endtask

  // Advances until the first cycle after a cic_rst pulse; counts cycles spent and cic_rst-high cycles
  task automatic wait_flush(input string name, output int total, output int high);
    bit seen = 1'b0;
    total = 0;
    high  = 0;
    for (int i = 0; i < 20000; i++) begin
      if (cic_rst === 1'b1) begin
        seen = 1'b1;
        high++;
      end else if (seen) begin
        return;
      end
      total++;
      tick();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_flush: no flush completion in 20000 cycles, required completion", name);
  endtask

  // Called in a SETTLE cycle; returns on the first RUN cycle
  task automatic settle_check(input string name);
    int n = 0;
    bit early = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (out_en !== 1'b0) early = 1'b1;
      if (dclk_rise_seen) n++;
      if (n == 5) begin
        n_cmp++;
        if (early) begin
          n_fail++;
          $display("FAIL %s_gate: out_en got 1 before 5th edge, required 0", name);
        end
        tick();
        n_cmp++;
        if ({out_en, busy, cfg_bus.cfg_ready} !== 3'b101) begin
          n_fail++;
          $display("FAIL %s_run: {out_en,busy,ready} got %b, required 101", name,
                   {out_en, busy, cfg_bus.cfg_ready});
        end
        return;
      end
      tick();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_settle: 5 edges not seen in 2000 cycles, required RUN", name);
  endtask

  task automatic test_reset();
    int total, high;
    rst = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ratio = 16'd0;
    repeat (3) tick();
    n_cmp++;
    if ({cfg_bus.cfg_ready, cfg_bus.cfg_err, cic_rst, out_en, busy, fault} !== 6'b001010) begin
      n_fail++;
      $display("FAIL reset_flags: {rdy,err,cic_rst,out_en,busy,fault} got %b, required 001010",
               {cfg_bus.cfg_ready, cfg_bus.cfg_err, cic_rst, out_en, busy, fault});
    end
    n_cmp++;
    if (cic_ratio !== 16'd64 || cic_shift !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_cfg: ratio/shift got %0d/%0d, required 64/0", cic_ratio, cic_shift);
    end
    rst = 1'b0;
    wait_flush("reset", total, high);
    // 7 CALC cycles at ratio 64 keep the reset-level cic_rst, then 8 FLUSH cycles
    n_cmp++;
    if (total != 15 || high != 15) begin
      n_fail++;
      $display("FAIL reset_seq: cycles/high got %0d/%0d, required 15/15", total, high);
    end
    n_cmp++;
    if (cic_shift !== 6'd30 || cic_ratio !== 16'd64) begin
      n_fail++;
      $display("FAIL reset_shift: shift/ratio got %0d/%0d, required 30/64", cic_shift, cic_ratio);
    end
    settle_check("reset");
  endtask

  task automatic test_range_err();
    logic [15:0] bad_ratios [2];
    bad_ratios[0] = 16'd1;
    bad_ratios[1] = 16'd5000;
    for (int i = 0; i < 2; i++) begin
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_ratio = bad_ratios[i];
      tick();
      cfg_bus.cfg_valid = 1'b0;
      n_cmp++;
      if (cfg_bus.cfg_err !== 1'b1) begin
        n_fail++;
        $display("FAIL range_err_pulse(%0d): cfg_err got %b, required 1", bad_ratios[i],
                 cfg_bus.cfg_err);
      end
      tick();
      n_cmp++;
      if ({cfg_bus.cfg_err, out_en, busy, cic_rst} !== 4'b0100 || cic_ratio !== 16'd64) begin
        n_fail++;
        $display("FAIL range_err_after(%0d): {err,out_en,busy,cic_rst} %b ratio %0d, required 0100 64",
                 bad_ratios[i], {cfg_bus.cfg_err, out_en, busy, cic_rst}, cic_ratio);
      end
    end
  endtask

  task automatic test_same_ratio();
    bit bad = 1'b0;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ratio = 16'd64;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    repeat (4) begin
      if (cic_rst !== 1'b0 || cfg_bus.cfg_err !== 1'b0 || busy !== 1'b0
          || cfg_bus.cfg_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL same_ratio: reconfig or error seen, required none");
    end
  endtask

  task automatic test_reconfig(input string name, input logic [15:0] ratio, input int exp_total,
                               input logic [5:0] exp_shift);
    int total, high;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ratio = ratio;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    n_cmp++;
    if ({cfg_bus.cfg_ready, busy, out_en, cic_rst} !== 4'b0110) begin
      n_fail++;
      $display("FAIL %s_accept: {ready,busy,out_en,cic_rst} got %b, required 0110", name,
               {cfg_bus.cfg_ready, busy, out_en, cic_rst});
    end
    wait_flush(name, total, high);
    n_cmp++;
    if (total != exp_total || high != 8) begin
      n_fail++;
      $display("FAIL %s_seq: cycles/high got %0d/%0d, required %0d/8", name, total, high,
               exp_total);
    end
    n_cmp++;
    if (cic_ratio !== ratio || cic_shift !== exp_shift) begin
      n_fail++;
      $display("FAIL %s_cfg: ratio/shift got %0d/%0d, required %0d/%0d", name, cic_ratio,
               cic_shift, ratio, exp_shift);
    end
    settle_check(name);
  endtask

  task automatic test_held_request_rst();
    int total, high;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ratio = 16'd128;
    tick();
    cfg_bus.cfg_ratio = 16'd32;
    for (int i = 0; i < 50 && cic_rst !== 1'b1; i++) tick();
    tick();
    n_cmp++;
    if (cic_ratio !== 16'd128 || cic_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL held_flush: ratio/cic_rst got %0d/%b, required 128/1", cic_ratio, cic_rst);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({cfg_bus.cfg_ready, cic_rst, out_en, busy} !== 4'b0101 || cic_ratio !== 16'd64) begin
      n_fail++;
      $display("FAIL held_rst: {ready,cic_rst,out_en,busy} %b ratio %0d, required 0101 64",
               {cfg_bus.cfg_ready, cic_rst, out_en, busy}, cic_ratio);
    end
    rst = 1'b0;
    wait_flush("held_reset", total, high);
    n_cmp++;
    if (cic_ratio !== 16'd64 || cfg_bus.cfg_ready !== 1'b0 || total != 15) begin
      n_fail++;
      $display("FAIL held_settle: ratio/ready/cycles got %0d/%b/%0d, required 64/0/15",
               cic_ratio, cfg_bus.cfg_ready, total);
    end
    settle_check("held");
    tick();
    cfg_bus.cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_accept: ready/busy got %b/%b, required 0/1", cfg_bus.cfg_ready, busy);
    end
    wait_flush("held32", total, high);
    n_cmp++;
    if (total != 14 || high != 8 || cic_ratio !== 16'd32 || cic_shift !== 6'd25) begin
      n_fail++;
      $display("FAIL held32_cfg: cycles/high/ratio/shift %0d/%0d/%0d/%0d, required 14/8/32/25",
               total, high, cic_ratio, cic_shift);
    end
    settle_check("held32");
  endtask

  task automatic test_timeout();
    int total, high;
    bit bad = 1'b0;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ratio = 16'd64;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    dclk_en = 1'b0;
    wait_flush("stuck", total, high);
    n_cmp++;
    if (total != 15 || high != 8) begin
      n_fail++;
      $display("FAIL stuck_seq: cycles/high got %0d/%0d, required 15/8", total, high);
    end
`ifdef CIC_DECIM_CTRL_TIMEOUT_EN
    repeat (8207) begin
      if (fault !== 1'b0 || cic_rst !== 1'b0) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad || fault !== 1'b0 || cic_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_early: fault/cic_rst got %b/%b before 8208 cycles, required 0/0", fault,
               cic_rst);
    end
    tick();
    n_cmp++;
    if ({fault, cic_rst, busy, out_en} !== 4'b1110) begin
      n_fail++;
      $display("FAIL wd_fire: {fault,cic_rst,busy,out_en} got %b, required 1110",
               {fault, cic_rst, busy, out_en});
    end
    dclk_en = 1'b1;
    wait_flush("wd_reflush", total, high);
    n_cmp++;
    if (high != 8 || cic_ratio !== 16'd64 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_reflush: high/ratio/fault got %0d/%0d/%b, required 8/64/1", high,
               cic_ratio, fault);
    end
    settle_check("wd");
    n_cmp++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: fault got %b, required 1", fault);
    end
`else
    repeat (8300) begin
      if ({fault, cic_rst, busy, out_en} !== 4'b0010) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL stuck_hold: left SETTLE or fault set, required SETTLE with fault 0");
    end
    dclk_en = 1'b1;
    settle_check("stuck");
`endif
  endtask

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ratio = 16'd0;
    test_reset();
    test_range_err();
    test_same_ratio();
    test_reconfig("r100", 16'd100, 16, 6'd35);
    test_reconfig("r4096", 16'd4096, 21, 6'd56);
    test_held_request_rst();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Configuration sequencer for the 5-stage CIC decimator in the SDR receive chain. Accepts decimation-ratio change requests over a valid/ready handshake and range-checks them. Computes the matching output scaling shift, then resets and flushes the filter. Holds downstream output disabled until the comb section has produced enough samples to settle.

Parameters:
STAGES, 5, number of integrator/comb stages (bit growth per ratio doubling)
MIN_RATIO, 2, smallest legal decimation ratio
MAX_RATIO, 4096, largest legal decimation ratio
DEFAULT_RATIO, 64, ratio applied after reset
FLUSH_CYCLES, 8, clk cycles cic_rst is held high per reconfiguration (>=1)
SETTLE_SAMPLES, 5, cic_dclk rising edges required before out_en
SHIFT_MAX, 56, saturation limit of cic_shift (accumulator width minus output width)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  ratio request valid
cfg_ratio  in  16  requested decimation ratio (unsigned)
cfg_ready  out  1  controller can accept a request
cfg_err  out  1  one-cycle pulse: request rejected (out of range)
cic_dclk  in  1  CIC output-sample clock/strobe
cic_rst  out  1  reset to CIC datapath
cic_ratio  out  16  decimation ratio driven to CIC
cic_shift  out  6  arithmetic right shift applied to CIC output
out_en  out  1  downstream sample enable (filter settled)
busy  out  1  high in every state except RUN
fault  out  1  sticky settle-timeout flag (see Optional Feature)

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values: cfg_ready 0, cfg_err 0, cic_rst 1, cic_ratio DEFAULT_RATIO, cic_shift 0, out_en 0, busy 1, fault 0, pend_ratio DEFAULT_RATIO, dclk_q 1.
- After reset, FSM enters CALC with pend_ratio = DEFAULT_RATIO.
- Rising-edge detect: edge = cic_dclk & ~dclk_q. dclk_q resets to 1 so a level that is already high never counts as an edge.
- States:
  - RUN: cfg_ready=1, busy=0, out_en=1, cic_rst=0.
    - On cfg_valid&cfg_ready with ratio < MIN_RATIO or > MAX_RATIO: cfg_err=1 next cycle for exactly 1 cycle; stay in RUN; outputs undisturbed.
    - With ratio == cic_ratio: accept; no reconfiguration; no cfg_err.
    - Otherwise: latch pend_ratio; next cycle cfg_ready=0 and go to CALC.
  - CALC: k starts at 0. Each cycle: if (1<<k) >= pend_ratio, register cic_shift_next = min(STAGES*k, SHIFT_MAX) and go to FLUSH; else k++. Duration is ceil_log2(pend_ratio)+1 cycles. out_en and cic_rst keep their prior values.
  - FLUSH: on entry (first cycle), cic_ratio <= pend_ratio and cic_shift <= cic_shift_next. cic_rst=1 and out_en=0 for exactly FLUSH_CYCLES cycles, then go to SETTLE.
  - SETTLE: cic_rst=0, out_en=0. Count edges; at the SETTLE_SAMPLES-th edge go to RUN, with out_en=1 from the following cycle.
- cfg_ready is 0 in CALC, FLUSH and SETTLE. The requester must hold cfg_valid/cfg_ratio; a held request is accepted on the first RUN cycle.
- cfg_valid while cfg_ready=0: not accepted, no cfg_err.
- rst asserted in any state restores reset values next cycle and restarts at CALC with DEFAULT_RATIO; an in-flight request is discarded.
- Edge counter clears on entry to SETTLE; edges outside SETTLE are ignored.
- cic_ratio and cic_shift change only on the FLUSH entry cycle, never while cic_rst=0.

Optional Feature:
Macro CIC_DECIM_CTRL_TIMEOUT_EN.
- Defined: SETTLE also runs a watchdog counter cleared on SETTLE entry and on every edge. If it reaches 2*MAX_RATIO+16 cycles without an edge: fault set (sticky until rst), FSM re-enters FLUSH with the same ratio, and the edge count restarts.
- Not defined: no watchdog; SETTLE waits indefinitely; fault tied to 0.

Test Plan:
- Reset release, cic_dclk toggling with period 64 -> CALC 7 cycles, cic_shift=30, cic_rst high exactly 8 cycles; out_en=1 the cycle after the 5th dclk edge; cfg_ready=1 in RUN.
- In RUN, request ratio 100 -> cfg_ready drops next cycle; cic_ratio=100 and cic_shift=35 on FLUSH entry; out_en=0 until 5 edges counted.
- Requests ratio 1 and ratio 5000 -> each gives a single-cycle cfg_err; cic_ratio stays 64; out_en stays 1.
- Request ratio 4096 -> cic_shift saturates to 56; request 64 while in RUN at 64 -> accepted, no cic_rst pulse, no cfg_err.
- cfg_valid held high with ratio 32 during SETTLE, then rst mid-FLUSH -> no accept before RUN; after rst, cic_ratio=64 and the request is accepted on the first RUN cycle.
- With CIC_DECIM_CTRL_TIMEOUT_EN defined, cic_dclk stuck low in SETTLE -> fault=1 after 8208 cycles and FLUSH re-entered; without the macro -> remains in SETTLE with fault=0.
